// File: rtl/rr_arb_quantum.sv
// Round-robin arbiter with per-grant quantum and a mandatory idle turnaround
// cycle between grants; all outputs registered.
module rr_arb_quantum #(
    parameter int N       = 4,
    parameter int QUANTUM = 8,
    parameter int IDW     = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id,
    output logic           busy
);

    localparam int CW = (QUANTUM < 2) ? 1 : $clog2(QUANTUM + 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   grant_q, grant_d;

    logic [IDW-1:0] win;
    logic           found;
    int             j;

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        win   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr_q) + k) % N;
            if (req[j]) begin
                win   = IDW'(j);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d      = GRANT;
                    owner_d      = win;
                    cnt_d        = CW'(1);
                    grant_d      = '0;
                    grant_d[win] = 1'b1;
                    ptr_d        = (win == IDW'(N - 1)) ? '0 : win + 1'b1;
                end
            end
            GRANT: begin
                if (!req[owner_q] ||
                    (QUANTUM != 0 && cnt_q == CW'(QUANTUM))) begin
                    state_d = IDLE;
                    grant_d = '0;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
        end
    end

    assign grant    = grant_q;
    assign grant_id = owner_q;
    assign busy     = |grant_q;

endmodule

// File: tb/tb_rr_arb_quantum.sv
// Bench for rr_arb_quantum: QUANTUM=4 and QUANTUM=0 instances on shared
// stimulus, checked against a behavioural model plus literal expectations.
module tb_rr_arb_quantum;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;

    logic [N-1:0] g4, g0;
    logic [1:0]   id4, id0;
    logic         b4, b0;

    int compared   = 0;
    int mismatched = 0;
    bit chk_en     = 1'b0;

    always #5 clk = ~clk;

    rr_arb_quantum #(.N(N), .QUANTUM(4)) dut (
        .clk(clk), .rst(rst), .req(req),
        .grant(g4), .grant_id(id4), .busy(b4)
    );

    rr_arb_quantum #(.N(N), .QUANTUM(0)) dut0 (
        .clk(clk), .rst(rst), .req(req),
        .grant(g0), .grant_id(id0), .busy(b0)
    );

    // Model: who owns the resource, how long it has held it, next priority.
    int m_qnt  [2] = '{4, 0};
    int m_own  [2];
    int m_held [2];
    int m_ptr  [2];
    bit m_busy [2];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_own[d]  = 0;
                m_held[d] = 0;
                m_ptr[d]  = 0;
                m_busy[d] = 1'b0;
            end else if (m_busy[d]) begin
                if (!req[m_own[d]] ||
                    (m_qnt[d] != 0 && m_held[d] == m_qnt[d]))
                    m_busy[d] = 1'b0;
                else
                    m_held[d]++;
            end else if (req != 0) begin
                for (int k = 0; k < N; k++) begin
                    if (!m_busy[d] && req[(m_ptr[d] + k) % N]) begin
                        m_own[d]  = (m_ptr[d] + k) % N;
                        m_busy[d] = 1'b1;
                    end
                end
                m_held[d] = 1;
                m_ptr[d]  = (m_own[d] + 1) % N;
            end
        end
        chk_en = 1'b1;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h @%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] exp_grant(input int d);
        return m_busy[d] ? N'(1) << m_own[d] : '0;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("q4_grant", 32'(g4), 32'(exp_grant(0)));
            chk("q4_id", 32'(id4), 32'(m_own[0]));
            chk("q4_busy", 32'(b4), 32'(m_busy[0]));
            chk("q0_grant", 32'(g0), 32'(exp_grant(1)));
            chk("q0_id", 32'(id0), 32'(m_own[1]));
            chk("q0_busy", 32'(b0), 32'(m_busy[1]));
        end
    end

    task automatic rst_pulse();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [N-1:0] e;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Idle with no requests
        repeat (20) @(negedge clk);
        chk("t1_grant", 32'(g4), 32'h0);
        chk("t1_id", 32'(id4), 32'h0);
        chk("t1_busy", 32'(b4), 32'h0);

        // Single short request to requester 2
        req = 4'b0100;
        @(negedge clk);
        chk("t2_grant", 32'(g4), 32'h4);
        chk("t2_id", 32'(id4), 32'h2);
        chk("t2_busy", 32'(b4), 32'h1);
        @(negedge clk);
        req = 4'b0000;
        @(negedge clk);
        chk("t2_release", 32'(g4), 32'h0);

        // Pointer wrap: ptr now 3, so 0 wins before 1
        req = 4'b0011;
        @(negedge clk);
        chk("t4_first", 32'(g4), 32'h1);
        chk("t4_first_id", 32'(id4), 32'h0);
        @(negedge clk);
        req = 4'b0010;
        @(negedge clk);
        chk("t4_gap", 32'(g4), 32'h0);
        @(negedge clk);
        chk("t4_second", 32'(g4), 32'h2);
        chk("t4_second_id", 32'(id4), 32'h1);
        req = 4'b0000;
        repeat (2) @(negedge clk);

        // All requesting: 4 on, 1 off, rotating
        rst_pulse();
        req = 4'b1111;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            e = (c % 5 < 4) ? N'(1) << ((c / 5) % 4) : '0;
            chk("t3_seq", 32'(g4), 32'(e));
            chk("t3_q0", 32'(g0), 32'h1);
        end

        // Reset in the middle of a grant to requester 3
        rst_pulse();
        req = 4'b1000;
        repeat (2) @(negedge clk);
        chk("t5_pre", 32'(g4), 32'h8);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_rst_grant", 32'(g4), 32'h0);
        chk("t5_rst_id", 32'(id4), 32'h0);
        req = 4'b1010;
        @(negedge clk);
        chk("t5_after", 32'(g4), 32'h2);
        chk("t5_after_q0", 32'(g0), 32'h2);

        // Lone requester held
        rst_pulse();
        req = 4'b0001;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            e = (c % 5 < 4) ? 4'b0001 : 4'b0000;
            chk("t6_q4", 32'(g4), 32'(e));
            chk("t6_q0", 32'(g0), 32'h1);
        end
        req = '0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/rr_arb_quantum.md
# rr_arb_quantum

Round-robin arbiter that shares one resource among N requesters. Each grant is held while the owner keeps its request asserted, up to a per-grant quantum. After every grant the priority pointer rotates, so a requester that holds its request continuously cannot starve the others. The block sits between the request sources and the shared resource's select/enable. It replaces fixed-state priority sequencing with a parameterized, registered-output arbiter.

## Interface
- N, default 4: number of requesters, 2..16.
- QUANTUM, default 8: maximum number of consecutive cycles one grant may be held. 0 means no limit.
- IDW, default $clog2(N): width of grant_id. Derived; never overridden.

- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  reset; synchronous, active-high.
- req  in  N  level request; bit i = requester i wants the resource.
- grant  out  N  registered grant; one-hot or all-zero.
- grant_id  out  IDW  index of current owner; holds the last owner when grant = 0.
- busy  out  1  high exactly when grant != 0.

## Operation
- State machine: IDLE, GRANT.
- Internal registers:
  - ptr (IDW bits): highest-priority index for the next arbitration.
  - owner (IDW bits).
  - cnt: counts grant cycles, sized to hold QUANTUM.
- IDLE:
  - If req == 0, stay in IDLE.
  - Otherwise pick the first set bit of req, searching ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - Set owner and grant_id to that index, set grant to the matching one-hot, set cnt = 1, go to GRANT.
  - Set ptr = (winner + 1) mod N. ptr wraps from N-1 to 0.
- GRANT, evaluated at each rising edge:
  - req[owner] == 0: release. grant clears, go to IDLE.
  - QUANTUM != 0 and cnt == QUANTUM: forced release, even if req[owner] is still 1. grant clears, go to IDLE.
  - Otherwise: hold the grant, cnt = cnt + 1. cnt saturates when QUANTUM == 0.
- Requests from non-owners during GRANT are ignored; they compete at the next IDLE arbitration.
- There is always at least one grant-free IDLE cycle between consecutive grants. This gives the shared resource a turnaround cycle. It also applies when the same requester is re-granted.
- A requester that is alone and holds req continuously gets QUANTUM cycles on, 1 cycle off, repeating.
- grant is never multi-hot. busy is equivalent to |grant.
- rst high at any edge:
  - grant = 0, grant_id = 0, busy = 0.
  - ptr = 0, owner = 0, cnt = 0, state = IDLE.
  - rst overrides any arbitration or release in that cycle.

## Timing
- All outputs are registered; there are no combinational paths from req to outputs.
- Grant latency: req rises before edge k while in IDLE → grant is visible after edge k (1 cycle).
- Release latency: req[owner] falls before edge k → grant is 0 after edge k. The earliest new grant appears after edge k+1.
- Quantum: grant is high for at most QUANTUM consecutive cycles. The cycle after that is always grant = 0.
- Worst-case wait for a requester holding req: (N-1)·(QUANTUM+1) cycles plus the current remaining grant.
- Reset: outputs are 0 in the cycle after the first edge with rst = 1. Arbitration resumes at the first edge with rst = 0.

## Test plan
Use N=4, QUANTUM=4 unless stated.
1. Reset, then req=0000 for 20 cycles → grant=0000, busy=0, grant_id=0 throughout.
2. Single short request:
   - req=0100 before edge 1 → grant=0100, grant_id=2, busy=1 after edge 1.
   - Drop req before edge 3 → grant=0000 after edge 3.
3. req=1111 held → repeating grant sequence: 0001×4, 0000, 0010×4, 0000, 0100×4, 0000, 1000×4, 0000, 0001×4…
4. Pointer wrap:
   - Grant requester 2, then release; ptr is now 3.
   - Apply req=0011 → grant=0001 (id 0) first, then 0010 after its release plus one idle cycle.
5. Reset mid-operation:
   - During a grant to 1000, pulse rst for one edge → grant=0000 the next cycle.
   - Then apply req=1010 → grant=0010 (ptr reset to 0).
6. Lone requester, req=0001 held:
   - With QUANTUM=4 → 4 cycles on, 1 off, repeating.
   - With QUANTUM=0 → grant=0001 held indefinitely, with no idle cycle.
